// File: rtl/tl_ul_arbiter_2to1_if.sv
// Bus bundle around the 2:1 TileLink UL arbiter: two upstream A/D channel
// pairs and the shared downstream A/D pair. The arbiter uses the slave view;
// the environment around it uses the master view.
interface tl_ul_arbiter_2to1_if;
  // upstream requester 0, A channel
  logic        a0_valid;
  logic        a0_ready;
  logic [2:0]  a0_opcode;
  logic [2:0]  a0_param;
  logic [2:0]  a0_size;
  logic [5:0]  a0_source;
  logic [24:0] a0_address;
  logic [3:0]  a0_mask;
  logic [31:0] a0_data;
  logic        a0_corrupt;
  // upstream requester 1, A channel
  logic        a1_valid;
  logic        a1_ready;
  logic [2:0]  a1_opcode;
  logic [2:0]  a1_param;
  logic [2:0]  a1_size;
  logic [5:0]  a1_source;
  logic [24:0] a1_address;
  logic [3:0]  a1_mask;
  logic [31:0] a1_data;
  logic        a1_corrupt;
  // upstream requester 0, D channel
  logic        d0_valid;
  logic        d0_ready;
  logic [2:0]  d0_opcode;
  logic [1:0]  d0_param;
  logic [2:0]  d0_size;
  logic [5:0]  d0_source;
  logic        d0_denied;
  logic [31:0] d0_data;
  logic        d0_corrupt;
  // upstream requester 1, D channel
  logic        d1_valid;
  logic        d1_ready;
  logic [2:0]  d1_opcode;
  logic [1:0]  d1_param;
  logic [2:0]  d1_size;
  logic [5:0]  d1_source;
  logic        d1_denied;
  logic [31:0] d1_data;
  logic        d1_corrupt;
  // shared downstream A channel
  logic        out_a_valid;
  logic        out_a_ready;
  logic [2:0]  out_a_opcode;
  logic [2:0]  out_a_param;
  logic [2:0]  out_a_size;
  logic [6:0]  out_a_source;
  logic [24:0] out_a_address;
  logic [3:0]  out_a_mask;
  logic [31:0] out_a_data;
  logic        out_a_corrupt;
  // shared downstream D channel
  logic        out_d_valid;
  logic        out_d_ready;
  logic [2:0]  out_d_opcode;
  logic [1:0]  out_d_param;
  logic [2:0]  out_d_size;
  logic [6:0]  out_d_source;
  logic        out_d_denied;
  logic [31:0] out_d_data;
  logic        out_d_corrupt;

  modport slave (
    input  a0_valid, a0_opcode, a0_param, a0_size, a0_source, a0_address, a0_mask, a0_data, a0_corrupt,
    output a0_ready,
    input  a1_valid, a1_opcode, a1_param, a1_size, a1_source, a1_address, a1_mask, a1_data, a1_corrupt,
    output a1_ready,
    output d0_valid, d0_opcode, d0_param, d0_size, d0_source, d0_denied, d0_data, d0_corrupt,
    input  d0_ready,
    output d1_valid, d1_opcode, d1_param, d1_size, d1_source, d1_denied, d1_data, d1_corrupt,
    input  d1_ready,
    output out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address,
    output out_a_mask, out_a_data, out_a_corrupt,
    input  out_a_ready,
    input  out_d_valid, out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_denied,
    input  out_d_data, out_d_corrupt,
    output out_d_ready
  );

  modport master (
    output a0_valid, a0_opcode, a0_param, a0_size, a0_source, a0_address, a0_mask, a0_data, a0_corrupt,
    input  a0_ready,
    output a1_valid, a1_opcode, a1_param, a1_size, a1_source, a1_address, a1_mask, a1_data, a1_corrupt,
    input  a1_ready,
    input  d0_valid, d0_opcode, d0_param, d0_size, d0_source, d0_denied, d0_data, d0_corrupt,
    output d0_ready,
    input  d1_valid, d1_opcode, d1_param, d1_size, d1_source, d1_denied, d1_data, d1_corrupt,
    output d1_ready,
    input  out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address,
    input  out_a_mask, out_a_data, out_a_corrupt,
    output out_a_ready,
    output out_d_valid, out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_denied,
    output out_d_data, out_d_corrupt,
    input  out_d_ready
  );
endinterface

// File: rtl/tl_ul_arbiter_2to1.sv
// 2:1 TileLink UL arbiter. Round-robin between two requesters with burst
// locking for multi-beat Puts and a per-requester outstanding-message cap.
// The requester index travels downstream in source[6] and steers D back.
// Both A and D paths are purely combinational; only control state is held.
module tl_ul_arbiter_2to1 #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input logic                  clock,
  input logic                  reset,
  tl_ul_arbiter_2to1_if.slave  bus
);

  localparam logic [3:0] LP_MAX_INFLIGHT = 4'(MAX_INFLIGHT);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Beats in a message of the given size on a 32-bit bus (sizes 6 and 7 -> 16).
  function automatic logic [4:0] f_beats(input logic [2:0] size);
    logic [4:0] beats;
    case (size)
      3'd0, 3'd1, 3'd2: beats = 5'd1;
      3'd3:             beats = 5'd2;
      3'd4:             beats = 5'd4;
      3'd5:             beats = 5'd8;
      default:          beats = 5'd16;
    endcase
    return beats;
  endfunction

  state_t          r_state, w_state_nxt;
  logic            r_lock_idx, w_lock_idx_nxt;
  logic            r_rr, w_rr_nxt;
  logic [3:0]      r_a_cnt, w_a_cnt_nxt;
  logic [1:0][3:0] r_inflight, w_inflight_nxt;
  logic [1:0][3:0] r_d_cnt, w_d_cnt_nxt;

  logic [1:0]  w_elig;
  logic        w_gnt_valid;
  logic        w_gnt_idx;
  logic [2:0]  w_sel_opcode;
  logic [2:0]  w_sel_size;
  logic        w_a_fire;
  logic [4:0]  w_a_beats;
  logic        w_d_idx;
  logic        w_d_fire;
  logic [4:0]  w_d_beats;
  logic        w_d_last;

  assign w_elig[0] = bus.a0_valid && (r_inflight[0] < LP_MAX_INFLIGHT);
  assign w_elig[1] = bus.a1_valid && (r_inflight[1] < LP_MAX_INFLIGHT);

  // Grant selection: a locked burst owner keeps the bus; otherwise favour r_rr.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = r_rr;
    if (r_state == ST_LOCKED) begin
      w_gnt_idx   = r_lock_idx;
      w_gnt_valid = r_lock_idx ? bus.a1_valid : bus.a0_valid;
    end else if (w_elig[r_rr]) begin
      w_gnt_idx   = r_rr;
      w_gnt_valid = 1'b1;
    end else if (w_elig[~r_rr]) begin
      w_gnt_idx   = ~r_rr;
      w_gnt_valid = 1'b1;
    end else begin
      w_gnt_idx   = r_rr;
      w_gnt_valid = 1'b0;
    end
  end

  assign w_sel_opcode = w_gnt_idx ? bus.a1_opcode : bus.a0_opcode;
  assign w_sel_size   = w_gnt_idx ? bus.a1_size   : bus.a0_size;

  // Downstream A follows the granted requester; handshakes are masked in reset.
  assign bus.out_a_valid   = w_gnt_valid && !reset;
  assign bus.out_a_opcode  = w_sel_opcode;
  assign bus.out_a_param   = w_gnt_idx ? bus.a1_param   : bus.a0_param;
  assign bus.out_a_size    = w_sel_size;
  assign bus.out_a_source  = {w_gnt_idx, (w_gnt_idx ? bus.a1_source : bus.a0_source)};
  assign bus.out_a_address = w_gnt_idx ? bus.a1_address : bus.a0_address;
  assign bus.out_a_mask    = w_gnt_idx ? bus.a1_mask    : bus.a0_mask;
  assign bus.out_a_data    = w_gnt_idx ? bus.a1_data    : bus.a0_data;
  assign bus.out_a_corrupt = w_gnt_idx ? bus.a1_corrupt : bus.a0_corrupt;
  assign bus.a0_ready      = w_gnt_valid && !w_gnt_idx && bus.out_a_ready && !reset;
  assign bus.a1_ready      = w_gnt_valid &&  w_gnt_idx && bus.out_a_ready && !reset;

  assign w_a_fire  = bus.out_a_valid && bus.out_a_ready;
  assign w_a_beats = ((w_sel_opcode == 3'd0) || (w_sel_opcode == 3'd1)) ? f_beats(w_sel_size) : 5'd1;

  // D steering by source[6]; payload fans out to both requesters unchanged.
  assign w_d_idx         = bus.out_d_source[6];
  assign bus.d0_valid    = bus.out_d_valid && !w_d_idx && !reset;
  assign bus.d1_valid    = bus.out_d_valid &&  w_d_idx && !reset;
  assign bus.out_d_ready = (w_d_idx ? bus.d1_ready : bus.d0_ready) && !reset;
  assign bus.d0_opcode   = bus.out_d_opcode;
  assign bus.d1_opcode   = bus.out_d_opcode;
  assign bus.d0_param    = bus.out_d_param;
  assign bus.d1_param    = bus.out_d_param;
  assign bus.d0_size     = bus.out_d_size;
  assign bus.d1_size     = bus.out_d_size;
  assign bus.d0_source   = bus.out_d_source[5:0];
  assign bus.d1_source   = bus.out_d_source[5:0];
  assign bus.d0_denied   = bus.out_d_denied;
  assign bus.d1_denied   = bus.out_d_denied;
  assign bus.d0_data     = bus.out_d_data;
  assign bus.d1_data     = bus.out_d_data;
  assign bus.d0_corrupt  = bus.out_d_corrupt;
  assign bus.d1_corrupt  = bus.out_d_corrupt;

  assign w_d_fire  = bus.out_d_valid && bus.out_d_ready;
  assign w_d_beats = (bus.out_d_opcode == 3'd1) ? f_beats(bus.out_d_size) : 5'd1;

  // Last D beat of a message: a fresh single-beat message, or the final count.
  always_comb begin
    w_d_last = 1'b0;
    if (r_d_cnt[w_d_idx] == 4'd0) begin
      w_d_last = (w_d_beats == 5'd1);
    end else begin
      w_d_last = (r_d_cnt[w_d_idx] == 4'd1);
    end
  end

  // Next-state: burst lock / round-robin pointer, inflight and D beat counters.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_idx_nxt = r_lock_idx;
    w_rr_nxt       = r_rr;
    w_a_cnt_nxt    = r_a_cnt;
    w_inflight_nxt = r_inflight;
    w_d_cnt_nxt    = r_d_cnt;

    case (r_state)
      ST_OPEN: begin
        if (w_a_fire) begin
          if (w_a_beats == 5'd1) begin
            w_rr_nxt = ~w_gnt_idx;
          end else begin
            w_state_nxt    = ST_LOCKED;
            w_lock_idx_nxt = w_gnt_idx;
            w_a_cnt_nxt    = 4'(w_a_beats - 5'd1);
          end
        end else begin
          w_state_nxt = ST_OPEN;
        end
      end
      ST_LOCKED: begin
        if (w_a_fire) begin
          if (w_a_cnt_nxt == 4'd1) begin
            w_state_nxt = ST_OPEN;
            w_a_cnt_nxt = 4'd0;
            w_rr_nxt    = ~r_lock_idx;
          end else begin
            w_a_cnt_nxt = r_a_cnt - 4'd1;
          end
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_OPEN;
        w_a_cnt_nxt = 4'd0;
      end
    endcase

    for (int i = 0; i < 2; i++) begin
      if (w_a_fire && (r_state == ST_OPEN) && (w_gnt_idx == i[0]) &&
          !(w_d_fire && w_d_last && (w_d_idx == i[0]))) begin
        w_inflight_nxt[i] = r_inflight[i] + 4'd1;
      end else if (!(w_a_fire && (r_state == ST_OPEN) && (w_gnt_idx == i[0])) &&
                   w_d_fire && w_d_last && (w_d_idx == i[0]) && (r_inflight[i] != 4'd0)) begin
        w_inflight_nxt[i] = r_inflight[i] - 4'd1;
      end else begin
        w_inflight_nxt[i] = r_inflight[i];
      end
    end

    if (w_d_fire) begin
      if (r_d_cnt[w_d_idx] == 4'd0) begin
        if (w_d_beats != 5'd1) begin
          w_d_cnt_nxt[w_d_idx] = 4'(w_d_beats - 5'd1);
        end else begin
          w_d_cnt_nxt[w_d_idx] = 4'd0;
        end
      end else begin
        w_d_cnt_nxt[w_d_idx] = r_d_cnt[w_d_idx] - 4'd1;
      end
    end else begin
      w_d_cnt_nxt = r_d_cnt;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_OPEN;
      r_lock_idx <= 1'b0;
      r_rr       <= 1'b0;
      r_a_cnt    <= 4'd0;
      r_inflight <= '0;
      r_d_cnt    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_idx_nxt;
      r_rr       <= w_rr_nxt;
      r_a_cnt    <= w_a_cnt_nxt;
      r_inflight <= w_inflight_nxt;
      r_d_cnt    <= w_d_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// Random-traffic bench for tl_ul_arbiter_2to1. A message-level reference
// model predicts each accepted downstream A beat and each routed D beat; the
// predictions are queued and a separate monitor compares them against the
// DUT whenever a handshake completes.
module tb_tl_ul_arbiter_2to1;
  localparam int MAXI   = 4;
  localparam int NCYCLE = 4000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tl_ul_arbiter_2to1_if bus();
  tl_ul_arbiter_2to1 #(.MAX_INFLIGHT(MAXI)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [6:0] src; logic [2:0] op; logic [2:0] param; logic [2:0] size;
    logic [24:0] addr; logic [3:0] mask; logic [31:0] data; logic corrupt;
  } abeat_t;
  typedef struct packed {
    logic dest; logic [2:0] op; logic [1:0] param; logic [2:0] size;
    logic [5:0] src; logic denied; logic [31:0] data; logic corrupt;
  } dbeat_t;
  typedef struct packed { logic [5:0] src; logic [2:0] op; logic [2:0] size; } preq_t;

  abeat_t exp_a[$];
  dbeat_t exp_d[$];
  preq_t  pq0[$], pq1[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int beats_of(input logic [2:0] size);
    if (size <= 3'd2) return 1;
    if (size >= 3'd6) return 16;
    return 1 << (int'(size) - 2);
  endfunction

  // ---------------- upstream requester drivers ----------------
  bit          has_msg[2];
  bit          av[2];
  logic [2:0]  m_op[2], m_param[2], m_size[2];
  logic [5:0]  m_src[2];
  logic [24:0] m_addr[2];
  logic [3:0]  a_mask[2];
  logic [31:0] a_data[2];
  logic        a_corr[2];
  int          m_beats[2], m_beat[2];
  bit          dr[2];

  task automatic new_msg(input int n);
    int r;
    r = $urandom % 4;
    m_op[n]    = (r == 0) ? 3'd0 : ((r == 1) ? 3'd1 : 3'd4);
    m_size[n]  = 3'($urandom % 8);
    m_param[n] = 3'($urandom);
    m_src[n]   = 6'($urandom);
    m_addr[n]  = 25'($urandom);
    m_beats[n] = (m_op[n] == 3'd4) ? 1 : beats_of(m_size[n]);
    m_beat[n]  = 0;
    has_msg[n] = 1'b1;
  endtask

  task automatic put_a(input int n);
    if (n == 0) begin
      bus.a0_valid = av[0]; bus.a0_opcode = m_op[0]; bus.a0_param = m_param[0];
      bus.a0_size = m_size[0]; bus.a0_source = m_src[0]; bus.a0_address = m_addr[0];
      bus.a0_mask = a_mask[0]; bus.a0_data = a_data[0]; bus.a0_corrupt = a_corr[0];
      bus.d0_ready = dr[0];
    end else begin
      bus.a1_valid = av[1]; bus.a1_opcode = m_op[1]; bus.a1_param = m_param[1];
      bus.a1_size = m_size[1]; bus.a1_source = m_src[1]; bus.a1_address = m_addr[1];
      bus.a1_mask = a_mask[1]; bus.a1_data = a_data[1]; bus.a1_corrupt = a_corr[1];
      bus.d1_ready = dr[1];
    end
  endtask

  // ---------------- reference model state ----------------
  int fav, owner, left;
  int outst[2];
  bit d_active;
  int d_left, withhold;
  preq_t d_req;
  bit d_dest;

  task automatic model_reset();
    fav = 0; owner = -1; left = 0; outst[0] = 0; outst[1] = 0;
    pq0.delete(); pq1.delete();
    d_active = 1'b0; d_left = 0; withhold = 0;
    has_msg[0] = 1'b0; has_msg[1] = 1'b0;
  endtask

  // Downstream D payload for the current cycle (random when idle).
  logic       odv;
  logic [2:0] d_op;
  logic [1:0] d_param;
  logic       d_den, d_corr;
  logic [31:0] d_data;
  bit          oar;

  task automatic randomize_inputs(input bit all_valid);
    for (int n = 0; n < 2; n++) begin
      if (!has_msg[n]) new_msg(n);
      av[n] = all_valid ? 1'b1 : (has_msg[n] && ($urandom % 4 != 0));
      a_mask[n] = 4'($urandom); a_data[n] = $urandom; a_corr[n] = 1'($urandom);
      dr[n] = all_valid ? 1'b1 : ($urandom % 4 != 0);
      put_a(n);
    end
  endtask

  // ---------------- stimulus + expectation generation ----------------
  initial begin : stim
    int  g;
    bit  gv, afire, dfire, force_both, elig0, elig1;
    int  inj;
    logic [5:0] exp_h;
    reset = 1'b1;
    model_reset();
    force_both = 1'b0;
    inj = 0;
    // Reset phase: drive live-looking traffic; every handshake output must stay low.
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      randomize_inputs(1'b1);
      bus.out_a_ready = 1'b1; bus.out_d_valid = 1'b1; bus.out_d_source = 7'($urandom);
      bus.out_d_opcode = 3'd0; bus.out_d_param = 2'd0; bus.out_d_size = 3'd0;
      bus.out_d_denied = 1'b0; bus.out_d_data = 32'd0; bus.out_d_corrupt = 1'b0;
      #4;
      check("reset_outputs", {bus.out_a_valid, bus.a0_ready, bus.a1_ready,
                              bus.d0_valid, bus.d1_valid, bus.out_d_ready}, 6'd0);
    end
    model_reset();
    force_both = 1'b1;
    @(posedge clock); #1;

    for (int cyc = 0; cyc < NCYCLE; cyc++) begin
      reset = 1'b0;
      if (inj < 2 && cyc > (inj + 1) * 1300 && owner >= 0 && left >= 2) begin
        // Reset in the middle of a locked burst.
        inj++;
        reset = 1'b1;
        randomize_inputs(1'b1);
        bus.out_a_ready = 1'b1; bus.out_d_valid = 1'b1;
        #4;
        check("midburst_reset_outputs", {bus.out_a_valid, bus.a0_ready, bus.a1_ready,
                                         bus.d0_valid, bus.d1_valid, bus.out_d_ready}, 6'd0);
        model_reset();
        force_both = 1'b1;
      end else begin
        randomize_inputs(force_both);
        force_both = 1'b0;
        oar = ($urandom % 4 != 0);
        bus.out_a_ready = oar;

        // D source: occasionally withhold responses so the inflight cap is hit.
        if (withhold > 0) withhold--;
        else if (!d_active && ($urandom % 50 == 0)) withhold = $urandom_range(10, 40);
        if (!d_active && withhold == 0 && (pq0.size() > 0 || pq1.size() > 0)) begin
          if (pq0.size() > 0 && (pq1.size() == 0 || ($urandom % 2 == 0))) begin
            d_req = pq0.pop_front(); d_dest = 1'b0;
          end else begin
            d_req = pq1.pop_front(); d_dest = 1'b1;
          end
          d_active = 1'b1;
          d_left = (d_req.op == 3'd4) ? beats_of(d_req.size) : 1;
        end
        odv = d_active && ($urandom % 4 != 0);
        d_op = (d_req.op == 3'd4) ? 3'd1 : 3'd0;
        d_param = 2'($urandom); d_den = 1'($urandom); d_data = $urandom; d_corr = 1'($urandom);
        if (!d_active) d_dest = 1'($urandom);
        bus.out_d_valid = odv; bus.out_d_opcode = d_op; bus.out_d_param = d_param;
        bus.out_d_size = d_req.size; bus.out_d_source = {d_dest, d_req.src};
        bus.out_d_denied = d_den; bus.out_d_data = d_data; bus.out_d_corrupt = d_corr;

        // Arbitration rules at message level.
        elig0 = av[0] && outst[0] < MAXI;
        elig1 = av[1] && outst[1] < MAXI;
        gv = 1'b0; g = fav;
        if (owner >= 0) begin
          g = owner; gv = av[owner];
        end else if (fav == 0 ? elig0 : elig1) begin
          g = fav; gv = 1'b1;
        end else if (fav == 0 ? elig1 : elig0) begin
          g = 1 - fav; gv = 1'b1;
        end
        afire = gv && oar;
        if (afire)
          exp_a.push_back({1'(g), m_src[g], m_op[g], m_param[g], m_size[g], m_addr[g],
                           a_mask[g], a_data[g], a_corr[g]});
        dfire = odv && dr[d_dest];
        if (dfire)
          exp_d.push_back({d_dest, d_op, d_param, d_req.size, d_req.src, d_den, d_data, d_corr});

        #4;
        exp_h = {gv, gv && g == 0 && oar, gv && g == 1 && oar,
                 odv && !d_dest, odv && d_dest, dr[d_dest]};
        check("handshakes", {bus.out_a_valid, bus.a0_ready, bus.a1_ready,
                             bus.d0_valid, bus.d1_valid, bus.out_d_ready}, exp_h);

        // Advance the model past this clock edge.
        if (afire) begin
          if (owner < 0) begin
            outst[g]++;
            if (m_beats[g] > 1) begin owner = g; left = m_beats[g] - 1; end
            else fav = 1 - g;
          end else begin
            left--;
            if (left == 0) begin owner = -1; fav = 1 - g; end
          end
          m_beat[g]++;
          if (m_beat[g] == m_beats[g]) begin
            if (g == 0) pq0.push_back({m_src[0], m_op[0], m_size[0]});
            else        pq1.push_back({m_src[1], m_op[1], m_size[1]});
            has_msg[g] = 1'b0;
          end
        end
        if (dfire) begin
          d_left--;
          if (d_left == 0) begin d_active = 1'b0; outst[d_dest]--; end
        end
      end
      @(posedge clock); #1;
    end
    reset = 1'b0;
    #4;
    check("a_leftover", 128'(exp_a.size()), 128'd0);
    check("d_leftover", 128'(exp_d.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- monitor: pop and compare on every handshake ----------------
  initial begin : mon
    abeat_t ea;
    dbeat_t ed;
    forever begin
      @(negedge clock);
      if (reset === 1'b0) begin
        if (bus.out_a_valid && bus.out_a_ready) begin
          if (exp_a.size() == 0) check("a_unexpected_beat", 128'd1, 128'd0);
          else begin
            ea = exp_a.pop_front();
            check("a_beat", {bus.out_a_source, bus.out_a_opcode, bus.out_a_param, bus.out_a_size,
                             bus.out_a_address, bus.out_a_mask, bus.out_a_data, bus.out_a_corrupt}, ea);
          end
        end
        if (bus.d0_valid && bus.d0_ready) begin
          if (exp_d.size() == 0) check("d0_unexpected_beat", 128'd1, 128'd0);
          else begin
            ed = exp_d.pop_front();
            check("d0_beat", {1'b0, bus.d0_opcode, bus.d0_param, bus.d0_size, bus.d0_source,
                              bus.d0_denied, bus.d0_data, bus.d0_corrupt}, ed);
          end
        end
        if (bus.d1_valid && bus.d1_ready) begin
          if (exp_d.size() == 0) check("d1_unexpected_beat", 128'd1, 128'd0);
          else begin
            ed = exp_d.pop_front();
            check("d1_beat", {1'b1, bus.d1_opcode, bus.d1_param, bus.d1_size, bus.d1_source,
                              bus.d1_denied, bus.d1_data, bus.d1_corrupt}, ed);
          end
        end
      end
    end
  end

endmodule
